// File: rtl/video_pkg.sv
// Shared video-unit constants, fill-engine FSM states and the tile-field mask helper.
package video_pkg;

    localparam int TILES_H     = 28;
    localparam int TILES_V     = 18;
    localparam int TILES_TOTAL = TILES_H * TILES_V;
    localparam int VRAM_SIZE   = (TILES_TOTAL + 3) / 4;
    localparam int TILE_W      = $clog2(TILES_TOTAL);
    localparam int ADDR_W      = $clog2(VRAM_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_RD,
        ST_WR,
        ST_DONE
    } fill_state_e;

    // Sets the 2-bit fields of tiles first_k..last_k (inclusive) within one byte.
    function automatic logic [7:0] tile_field_mask(input logic [1:0] first_k,
                                                   input logic [1:0] last_k);
        logic [7:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            if (2'(k) >= first_k && 2'(k) <= last_k) m[2*k +: 2] = 2'b11;
        end
        return m;
    endfunction

endpackage

// File: rtl/vram_fill_engine_if.sv
// Command handshake and VRAM write-port bundle between the CPU/video side and the fill engine.
interface vram_fill_engine_if;
    import video_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [TILE_W-1:0] cmd_start;
    logic [TILE_W:0]   cmd_count;
    logic [1:0]        cmd_color;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_wenable;
    logic [7:0]        vram_rdata;

    modport master (
        output cmd_valid, cmd_start, cmd_count, cmd_color, vram_rdata,
        input  cmd_ready, vram_addr, vram_wdata, vram_wenable
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_count, cmd_color, vram_rdata,
        output cmd_ready, vram_addr, vram_wdata, vram_wenable
    );

endinterface

// File: rtl/vram_fill_engine_merge.sv
// Combinational per-byte coverage mask and read-modify-write merge for the fill engine.
module vram_fill_merge
    import video_pkg::*;
(
    input  logic [ADDR_W-1:0] b,
    input  logic [TILE_W-1:0] s,
    input  logic [TILE_W-1:0] e,
    input  logic [1:0]        color,
    input  logic [7:0]        rdata,
    output logic [7:0]        mask,
    output logic              is_full,
    output logic [7:0]        merged
);

    logic [1:0] first_k;
    logic [1:0] last_k;

    // Only the first and last bytes of the range can be partially covered.
    assign first_k = (s[TILE_W-1:2] == b) ? s[1:0] : 2'd0;
    assign last_k  = (e[TILE_W-1:2] == b) ? e[1:0] : 2'd3;

    assign mask    = tile_field_mask(first_k, last_k);
    assign is_full = (mask == 8'hFF);
    assign merged  = (rdata & ~mask) | ({4{color}} & mask);

endmodule

// File: rtl/vram_fill_engine.sv
// Tile fill engine: writes a palette index over a tile range, RMW only on edge bytes.
// Optional sticky completion interrupt under `define VRAM_FILL_IRQ_EN.
module vram_fill_engine
    import video_pkg::*;
(
    input  logic clk,
    input  logic rst,
    vram_fill_engine_if.slave bus,
    output logic busy,
    output logic done
`ifdef VRAM_FILL_IRQ_EN
    ,
    output logic irq,
    input  logic irq_ack
`endif
);

    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(TILES_TOTAL - 1);

    fill_state_e       state, state_nx;
    logic [TILE_W-1:0] s_q, e_q;
    logic [1:0]        color_q;
    logic [ADDR_W-1:0] b_q;
    logic [7:0]        rdata_q;

    logic              accept;
    logic              cmd_empty;
    logic [TILE_W+1:0] last_raw;
    logic [TILE_W-1:0] last_clamped;
    logic              last_byte;
    logic [7:0]        mask;
    logic              is_full;
    logic [7:0]        merged;

    assign accept       = bus.cmd_valid && bus.cmd_ready;
    assign cmd_empty    = (bus.cmd_count == '0) || (bus.cmd_start > LAST_TILE);
    assign last_raw     = {2'b00, bus.cmd_start} + {1'b0, bus.cmd_count} - (TILE_W+2)'(1);
    assign last_clamped = (last_raw > {2'b00, LAST_TILE}) ? LAST_TILE : last_raw[TILE_W-1:0];
    assign last_byte    = (b_q == e_q[TILE_W-1:2]);

    vram_fill_merge u_merge (
        .b       (b_q),
        .s       (s_q),
        .e       (e_q),
        .color   (color_q),
        .rdata   (rdata_q),
        .mask    (mask),
        .is_full (is_full),
        .merged  (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            s_q     <= '0;
            e_q     <= '0;
            color_q <= '0;
            b_q     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                s_q     <= bus.cmd_start;
                e_q     <= last_clamped;
                color_q <= bus.cmd_color;
                b_q     <= bus.cmd_start[TILE_W-1:2];
            end
            if (state == ST_RD) rdata_q <= bus.vram_rdata;
            if (state == ST_WR && !last_byte) b_q <= b_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nx         = state;
        bus.cmd_ready    = 1'b0;
        bus.vram_wenable = 1'b0;
        bus.vram_wdata   = '0;
        busy             = 1'b1;
        done             = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                busy          = 1'b0;
                if (bus.cmd_valid) state_nx = cmd_empty ? ST_DONE : ST_PICK;
            end
            ST_PICK: state_nx = is_full ? ST_WR : ST_RD;
            ST_RD:   state_nx = ST_WR;
            ST_WR: begin
                bus.vram_wenable = 1'b1;
                bus.vram_wdata   = merged;
                state_nx         = last_byte ? ST_DONE : ST_PICK;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Address is driven from PICK onward so registered-read VRAM has data ready by the end of RD.
    assign bus.vram_addr = b_q;

`ifdef VRAM_FILL_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= done | (irq_q & ~irq_ack);
    end

    // OR-ing done in makes irq visible in the done cycle itself.
    assign irq = irq_q | done;
`endif

endmodule

// File: tb/tb_vram_fill_engine.sv
// Self-checking bench for vram_fill_engine: tile-level model feeds a write scoreboard.
module tb_vram_fill_engine;
    import video_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, done, irq, irq_ack;
    int   checks = 0;
    int   failures = 0;
    int   wr_cnt = 0;
    wr_t  exp_q[$];
    logic [7:0] mem [VRAM_SIZE];

    vram_fill_engine_if bus();

    vram_fill_engine dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .done (done)
`ifdef VRAM_FILL_IRQ_EN
        ,
        .irq     (irq),
        .irq_ack (irq_ack)
`endif
    );

`ifndef VRAM_FILL_IRQ_EN
    assign irq = 1'b0;
`endif

    always #5 clk = ~clk;

    // Registered-read VRAM: data for the presented address appears one cycle later.
    always @(posedge clk) bus.vram_rdata <= mem[bus.vram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    always @(negedge clk) begin : write_monitor
        wr_t x;
        if (bus.vram_wenable) begin
            wr_cnt++;
            mem[bus.vram_addr] <= bus.vram_wdata;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_write observed addr=%0d data=%02h expected=no write",
                       bus.vram_addr, bus.vram_wdata);
            end else begin
                x = exp_q.pop_front();
                chk("wr_addr", 32'(bus.vram_addr), 32'(x.addr));
                chk("wr_data", 32'(bus.vram_wdata), 32'(x.data));
            end
        end
    end

    // Tile-level model: paint each covered tile, emit every touched byte in order.
    task automatic push_model(input int s, input int cnt, input logic [1:0] c, output int lat);
        int e;
        logic [7:0] v;
        bit full;
        lat = 1;
        if (cnt == 0 || s >= TILES_TOTAL) return;
        e = s + cnt - 1;
        if (e > TILES_TOTAL - 1) e = TILES_TOTAL - 1;
        for (int b = s / 4; b <= e / 4; b++) begin
            v = mem[b];
            full = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (4*b + k >= s && 4*b + k <= e) v[2*k +: 2] = c;
                else full = 1'b0;
            end
            exp_q.push_back('{addr: ADDR_W'(b), data: v});
            lat += full ? 2 : 3;
        end
    endtask

    task automatic issue(input int s, input int cnt, input int c);
        @(negedge clk);
        chk("ready_idle", 32'(bus.cmd_ready), 1);
        bus.cmd_start = TILE_W'(s);
        bus.cmd_count = (TILE_W+1)'(cnt);
        bus.cmd_color = 2'(c);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the command bus: the engine must work from its latched copy.
        bus.cmd_valid = 1'b0;
        bus.cmd_start = ~bus.cmd_start;
        bus.cmd_count = ~bus.cmd_count;
        bus.cmd_color = ~bus.cmd_color;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        @(negedge clk);
        chk("busy_after_accept", 32'(busy), 1);
        chk("ready_low_busy", 32'(bus.cmd_ready), 0);
        while (!done && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_cmd(input int s, input int cnt, input int c, input string tag, output int lat);
        int want_lat;
        push_model(s, cnt, 2'(c), want_lat);
        issue(s, cnt, c);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(want_lat));
        chk({tag, "_all_written"}, 32'(exp_q.size()), 0);
        @(negedge clk);
        chk({tag, "_idle_after"}, {30'd0, busy, done}, 0);
    endtask

    initial begin
        int lat, n0, s, cnt, c;
        bit found;
        bus.cmd_valid = 1'b0;
        bus.cmd_start = '0;
        bus.cmd_count = '0;
        bus.cmd_color = '0;
        irq_ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wen", 32'(bus.vram_wenable), 0);
        chk("rst_addr", 32'(bus.vram_addr), 0);
        chk("rst_wdata", 32'(bus.vram_wdata), 0);
        chk("rst_irq", 32'(irq), 0);
        rst = 1'b0;

        n0 = wr_cnt;
        run_cmd(0, 504, 2, "full", lat);
        chk("full_lat_253", 32'(lat), 253);
        chk("full_write_count", 32'(wr_cnt - n0), 126);
        chk("full_mem0", 32'(mem[0]), 32'h AA);
        chk("full_mem125", 32'(mem[125]), 32'h AA);

        run_cmd(4, 4, 0, "clear_b1", lat);
        n0 = wr_cnt;
        run_cmd(5, 2, 3, "single", lat);
        chk("single_writes", 32'(wr_cnt - n0), 1);
        chk("single_mem1", 32'(mem[1]), 32'h3C);
        chk("single_lat", 32'(lat), 4);

        run_cmd(0, 12, 3, "ones", lat);
        run_cmd(3, 6, 1, "edges", lat);
        chk("edges_mem0", 32'(mem[0]), 32'h7F);
        chk("edges_mem1", 32'(mem[1]), 32'h55);
        chk("edges_mem2", 32'(mem[2]), 32'hFD);
        chk("edges_lat", 32'(lat), 9);

        n0 = wr_cnt;
        run_cmd(10, 0, 1, "empty", lat);
        chk("empty_lat", 32'(lat), 1);
        run_cmd(504, 5, 1, "oob", lat);
        run_cmd(511, 1023, 2, "oob_max", lat);
        chk("empty_writes", 32'(wr_cnt - n0), 0);

        run_cmd(500, 10, 0, "clamp", lat);
        chk("clamp_mem125", 32'(mem[125]), 0);
        chk("clamp_lat", 32'(lat), 3);
        run_cmd(503, 1, 3, "last_tile", lat);
        chk("last_tile_mem125", 32'(mem[125]), 32'hC0);

        for (int i = 0; i < 10; i++) begin
            s   = int'($urandom_range(0, 511));
            cnt = (i % 2 == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 1023));
            c   = int'($urandom_range(0, 3));
            run_cmd(s, cnt, c, "rand", lat);
        end

        // Reset during the WR of byte 40: earlier bytes stay written, later ones untouched.
        run_cmd(0, 504, 2, "refill", lat);
        for (int b = 0; b < 40; b++) exp_q.push_back('{addr: ADDR_W'(b), data: 8'h55});
        issue(0, 504, 1);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.vram_wenable && bus.vram_addr == ADDR_W'(40)) found = 1'b1;
        end
        chk("reached_addr40", 32'(found), 1);
        rst = 1'b1;
        #1;
        chk("midrst_wen", 32'(bus.vram_wenable), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_pending", 32'(exp_q.size()), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_quiet", {29'd0, bus.cmd_ready, busy, done}, 32'b100);
        end
        chk("post_rst_mem39", 32'(mem[39]), 32'h55);
        chk("post_rst_mem40", 32'(mem[40]), 32'hAA);
        chk("post_rst_mem125", 32'(mem[125]), 32'hAA);

`ifdef VRAM_FILL_IRQ_EN
        chk("irq_low_after_rst", 32'(irq), 0);
        push_model(8, 4, 2'd3, n0);
        issue(8, 4, 3);
        wait_done(lat);
        chk("irq_with_done", {30'd0, done, irq}, 32'b11);
        repeat (3) begin
            @(negedge clk);
            chk("irq_sticky", 32'(irq), 1);
        end
        push_model(20, 3, 2'd1, n0);
        issue(20, 3, 1);
        wait_done(lat);
        chk("irq_second_done", 32'(done), 1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_set_wins", 32'(irq), 1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_ack_clears", 32'(irq), 0);
        @(negedge clk);
        chk("irq_stays_clear", 32'(irq), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
